// File: rtl/bram_seq_writer_pkg.sv
// Shared types for the sequential BRAM table writer: load FSM state encoding.
// No logic, no latency, no flow control.
package bram_seq_writer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bram_seq_writer_sdp_bram.sv
// Simple dual-port block RAM: one write port, one registered read port, read-first.
// Read latency 1 clock; no backpressure, a write happens on every cycle with we=1.
module bram_seq_writer_sdp_bram #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // Both updates are non-blocking, so a same-address read returns the old word.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/bram_seq_writer.sv
// Fills a BRAM table at addresses 0..depth-1 from a valid/ready word stream; rd_data has 1-clock latency.
// wr_ready is high only while loading; the source must hold wr_data until wr_valid && wr_ready.
module bram_seq_writer
   import bram_seq_writer_pkg::*;
#(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  wr_valid,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_ready,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   count,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   state_t                state;
   state_t                state_nx;
   logic [ADDR_WIDTH-1:0] waddr;
   logic                  wr_en;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      wr_en    = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = LOAD;
         end
         LOAD: begin
            wr_en = wr_valid && wr_ready;
            if (wr_en && (&waddr)) state_nx = DONE;
         end
         DONE: begin
            if (start) state_nx = LOAD;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Status flags are registered from the next state so they line up with state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         count    <= '0;
         waddr    <= '0;
      end else begin
         wr_ready <= (state_nx == LOAD);
         busy     <= (state_nx == LOAD);
         done     <= (state_nx == DONE);
         if ((state != LOAD) && start) begin
            waddr <= '0;
            count <= '0;
         end else if (wr_en) begin
            waddr <= waddr + ADDR_WIDTH'(1);
            count <= count + (ADDR_WIDTH+1)'(1);
         end
      end
   end

   bram_seq_writer_sdp_bram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (waddr),
      .wdata (wr_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_bram_seq_writer.sv
// Bench for bram_seq_writer: cycle model of the load FSM plus a read-data scoreboard.
module tb_bram_seq_writer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       wr_valid = 1'b0;
   logic [1:0] wr_data = '0;
   logic       wr_ready;
   logic       busy;
   logic       done;
   logic [3:0] count;
   logic [2:0] rd_addr = '0;
   logic [1:0] rd_data;

   int n_checks = 0;
   int n_fails  = 0;

   // reference model
   int         m_state = 0;   // 0 idle, 1 load, 2 done
   int         m_count = 0;
   int         m_waddr = 0;
   int         n_acc   = 0;
   logic [1:0] model_mem [8];
   logic [1:0] rq [$];
   bit         do_read = 1'b0;

   always #5 clk = ~clk;

   bram_seq_writer #(.ADDR_WIDTH(3), .DATA_WIDTH(2)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .busy     (busy),
      .done     (done),
      .count    (count),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_status(input string tag);
      check({tag, ".busy"},     32'(busy),     32'(m_state == 1));
      check({tag, ".wr_ready"}, 32'(wr_ready), 32'(m_state == 1));
      check({tag, ".done"},     32'(done),     32'(m_state == 2));
      check({tag, ".count"},    32'(count),    32'(m_count));
   endtask

   // One clock: model the edge from current inputs, then compare after it.
   task automatic tick(input string tag);
      int  ns = m_state;
      int  nc = m_count;
      int  nw = m_waddr;
      logic [1:0] exp_rd;
      if (do_read) rq.push_back(model_mem[rd_addr]);
      if (m_state != 1 && start) begin
         ns = 1; nc = 0; nw = 0;
      end else if (m_state == 1 && wr_valid) begin
         model_mem[m_waddr] = wr_data;
         n_acc++;
         nc = m_count + 1;
         nw = (m_waddr + 1) % 8;
         if (m_waddr == 7) ns = 2;
      end
      @(posedge clk);
      #1;
      m_state = ns; m_count = nc; m_waddr = nw;
      check_status(tag);
      if (do_read) begin
         exp_rd = rq.pop_front();
         check({tag, ".rd_data"}, 32'(rd_data), 32'(exp_rd));
      end
   endtask

   task automatic apply_reset(input string tag);
      reset_n = 1'b0;
      #2;
      m_state = 0; m_count = 0; m_waddr = 0;
      rq.delete();
      check_status(tag);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic pulse_start(input string tag);
      start = 1'b1;
      tick(tag);
      start = 1'b0;
   endtask

   task automatic read_all(input string tag);
      wr_valid = 1'b0;
      do_read  = 1'b1;
      for (int a = 0; a < 8; a++) begin
         rd_addr = 3'(a);
         tick(tag);
      end
      do_read = 1'b0;
   endtask

   initial begin
      logic [1:0] seq5 [8];
      int acc0;

      // reset state
      apply_reset("reset");

      // 1: continuous stream 0,1,2,3,0,1,2,3
      pulse_start("t1_start");
      wr_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wr_data = 2'(i % 4);
         tick("t1_stream");
      end
      check("t1_done_after_8", 32'(done), 32'd1);
      read_all("t1_read");

      // 3: wr_valid while DONE is ignored
      wr_valid = 1'b1;
      wr_data  = 2'b11;
      for (int i = 0; i < 3; i++) tick("t3_done_valid");
      read_all("t3_done_read");

      // 2: toggling wr_valid
      pulse_start("t2_start");
      acc0 = n_acc;
      for (int i = 0; i < 16; i++) begin
         wr_valid = (i % 2 == 0);
         wr_data  = 2'($urandom_range(0, 3));
         tick("t2_toggle");
      end
      check("t2_accepts", 32'(n_acc - acc0), 32'd8);
      check("t2_done", 32'(done), 32'd1);
      read_all("t2_read");

      // 4: start ignored at count=4, then reset at count=5
      pulse_start("t4_start");
      wr_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_data = 2'(3 - i);
         tick("t4_load");
      end
      start   = 1'b1;
      wr_data = 2'b10;
      tick("t4_start_in_load");
      start = 1'b0;
      check("t4_count5", 32'(count), 32'd5);
      wr_valid = 1'b0;
      start    = 1'b1;
      apply_reset("t4_reset");
      start = 1'b0;
      check("t4_reset_count", 32'(count), 32'd0);
      read_all("t4_read");

      // 3: wr_valid while IDLE is ignored
      wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) tick("t3_idle_valid");
      read_all("t3_idle_read");

      // 5: read-first on same-address collision
      seq5 = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b10};
      pulse_start("t5_prep_start");
      wr_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wr_data = seq5[i];
         tick("t5_prep");
      end
      pulse_start("t5_start");
      wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_data = 2'(i);
         tick("t5_load");
      end
      do_read = 1'b1;
      rd_addr = 3'd3;
      wr_data = 2'b10;
      tick("t5_collide");
      check("t5_old_data", 32'(rd_data), 32'(2'b01));
      wr_valid = 1'b0;
      tick("t5_reread");
      check("t5_new_data", 32'(rd_data), 32'(2'b10));
      do_read  = 1'b0;
      wr_valid = 1'b1;
      for (int i = 4; i < 8; i++) begin
         wr_data = 2'(i % 4);
         tick("t5_finish");
      end

      // 6: reload from DONE with all 3s
      check("t6_done_before", 32'(done), 32'd1);
      wr_valid = 1'b0;
      pulse_start("t6_start");
      check("t6_done_cleared", 32'(done), 32'd0);
      wr_valid = 1'b1;
      wr_data  = 2'b11;
      for (int i = 0; i < 8; i++) tick("t6_load");
      check("t6_done_again", 32'(done), 32'd1);
      read_all("t6_read");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
